// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial 32-bit ALU sequencer driving an external 1-bit slice
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ctrl_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        cout_o,
    output logic        overflow_o,
    output logic        slice_src1_o,
    output logic        slice_src2_o,
    output logic        slice_less_o,
    output logic        slice_ainvert_o,
    output logic        slice_binvert_o,
    output logic        slice_cin_o,
    output logic [1:0]  slice_op_o,
    input  logic        slice_result_i,
    input  logic        slice_cout_i
);

    localparam logic [3:0] c_ctrl_and = 4'b0000;
    localparam logic [3:0] c_ctrl_or  = 4'b0001;
    localparam logic [3:0] c_ctrl_add = 4'b0010;
    localparam logic [3:0] c_ctrl_sub = 4'b0110;
    localparam logic [3:0] c_ctrl_slt = 4'b0111;
    localparam logic [3:0] c_ctrl_nor = 4'b1100;

    localparam logic [1:0] c_op_or   = 2'b00;
    localparam logic [1:0] c_op_and  = 2'b01;
    localparam logic [1:0] c_op_add  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [3:0]  r_ctrl;
    logic [4:0]  r_idx;
    logic        r_carry;
    logic [30:0] r_acc;
    logic [31:0] r_result;
    logic        r_cout;
    logic        r_ovf;

    logic [1:0]  w_op;
    logic        w_ainv;
    logic        w_binv;
    logic        w_arith;
    logic        w_slt;
    logic        w_logic;
    logic        w_cin;
    logic        w_last;
    logic        w_ovf31;
    logic [31:0] w_sum_full;
    logic [31:0] w_fin_result;
    logic        w_fin_cout;
    logic        w_fin_ovf;

    // Decode from the latched control so late ctrl_i changes cannot leak in.
    always_comb begin
        w_op    = c_op_or;
        w_ainv  = 1'b0;
        w_binv  = 1'b0;
        w_arith = 1'b0;
        w_slt   = 1'b0;
        w_logic = 1'b0;
        case (r_ctrl)
            c_ctrl_and: begin w_op = c_op_and; w_logic = 1'b1; end
            c_ctrl_or:  begin w_op = c_op_or;  w_logic = 1'b1; end
            c_ctrl_add: begin w_op = c_op_add; w_arith = 1'b1; end
            c_ctrl_sub: begin w_op = c_op_add; w_binv = 1'b1; w_arith = 1'b1; end
            c_ctrl_slt: begin w_op = c_op_add; w_binv = 1'b1; w_slt = 1'b1; end
            c_ctrl_nor: begin
                w_op    = c_op_and;
                w_ainv  = 1'b1;
                w_binv  = 1'b1;
                w_logic = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cin  = (r_idx == 5'd0) ? w_binv : r_carry;
    assign w_last = (r_idx == 5'd31);

    // MSB results come straight from the slice on the final RUN cycle.
    assign w_ovf31    = w_cin ^ slice_cout_i;
    assign w_sum_full = {slice_result_i, r_acc};

    always_comb begin
        w_fin_result = 32'd0;
        w_fin_cout   = 1'b0;
        w_fin_ovf    = 1'b0;
        if (w_arith) begin
            w_fin_result = w_sum_full;
            w_fin_cout   = slice_cout_i;
            w_fin_ovf    = w_ovf31;
        end else if (w_slt) begin
            w_fin_result = {31'd0, slice_result_i ^ w_ovf31};
        end else if (w_logic) begin
            w_fin_result = w_sum_full;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        ready_o         = 1'b0;
        done_o          = 1'b0;
        slice_src1_o    = 1'b0;
        slice_src2_o    = 1'b0;
        slice_less_o    = 1'b0;
        slice_ainvert_o = 1'b0;
        slice_binvert_o = 1'b0;
        slice_cin_o     = 1'b0;
        slice_op_o      = 2'b00;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                slice_src1_o    = r_src1[r_idx];
                slice_src2_o    = r_src2[r_idx];
                slice_ainvert_o = w_ainv;
                slice_binvert_o = w_binv;
                slice_cin_o     = w_cin;
                slice_op_o      = w_op;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src1   <= 32'd0;
            r_src2   <= 32'd0;
            r_ctrl   <= 4'd0;
            r_idx    <= 5'd0;
            r_carry  <= 1'b0;
            r_acc    <= 31'd0;
            r_result <= 32'd0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src1 <= src1_i;
                        r_src2 <= src2_i;
                        r_ctrl <= ctrl_i;
                        r_idx  <= 5'd0;
                    end
                end
                S_RUN: begin
                    r_carry <= slice_cout_i;
                    if (w_last) begin
                        r_result <= w_fin_result;
                        r_cout   <= w_fin_cout;
                        r_ovf    <= w_fin_ovf;
                        r_idx    <= 5'd0;
                    end else begin
                        r_acc[r_idx] <= slice_result_i;
                        r_idx        <= r_idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = r_result;
    assign cout_o     = r_cout;
    assign overflow_o = r_ovf;
    assign zero_o     = (r_result == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Directed self-checking bench with a behavioural 1-bit slice
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ctrl_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        cout_o;
    logic        overflow_o;
    logic        slice_src1_o;
    logic        slice_src2_o;
    logic        slice_less_o;
    logic        slice_ainvert_o;
    logic        slice_binvert_o;
    logic        slice_cin_o;
    logic [1:0]  slice_op_o;
    logic        slice_result_i;
    logic        slice_cout_i;

    int total = 0;
    int bad   = 0;

    alu_serial_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .ctrl_i         (ctrl_i),
        .ready_o        (ready_o),
        .done_o         (done_o),
        .result_o       (result_o),
        .zero_o         (zero_o),
        .cout_o         (cout_o),
        .overflow_o     (overflow_o),
        .slice_src1_o   (slice_src1_o),
        .slice_src2_o   (slice_src2_o),
        .slice_less_o   (slice_less_o),
        .slice_ainvert_o(slice_ainvert_o),
        .slice_binvert_o(slice_binvert_o),
        .slice_cin_o    (slice_cin_o),
        .slice_op_o     (slice_op_o),
        .slice_result_i (slice_result_i),
        .slice_cout_i   (slice_cout_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference 1-bit ALU slice.
    logic w_a;
    logic w_b;
    always_comb begin
        w_a = slice_src1_o ^ slice_ainvert_o;
        w_b = slice_src2_o ^ slice_binvert_o;
        case (slice_op_o)
            2'b00:   slice_result_i = w_a | w_b;
            2'b01:   slice_result_i = w_a & w_b;
            2'b10:   slice_result_i = w_a ^ w_b ^ slice_cin_o;
            default: slice_result_i = slice_less_o;
        endcase
        slice_cout_i = (w_a & w_b) | (w_a & slice_cin_o) | (w_b & slice_cin_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation from a point #1 after a rising edge and checks
    // latency, the one-cycle done pulse and the final flags.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctl, input logic [31:0] exp_res,
                          input logic exp_cout, input logic exp_ovf);
        int n;
        src1_i  = a;
        src2_i  = b;
        ctrl_i  = ctl;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        src1_i  = 32'hDEAD_BEEF;
        src2_i  = 32'h1234_5678;
        ctrl_i  = 4'b0001;
        chk({tag, "_ready_busy"}, {31'd0, ready_o}, 32'd0);
        n = 0;
        while (!done_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd32);
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, exp_res == 32'd0});
        chk({tag, "_cout"}, {31'd0, cout_o}, {31'd0, exp_cout});
        chk({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, exp_ovf});
        @(posedge clk_i); #1;
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int n;
        int dcnt;
        rst_i   = 1'b1;
        start_i = 1'b0;
        src1_i  = 32'd0;
        src2_i  = 32'd0;
        ctrl_i  = 4'd0;
        #3;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_eq",  32'd5, 32'd5, 4'b0110, 32'd0, 1'b1, 1'b0);
        run_op("sub_neg", 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 32'd1, 1'b0, 1'b0);
        run_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 32'd0, 1'b0, 1'b0);
        run_op("nor",     32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("and",     32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0, 1'b0);
        run_op("or",      32'h0000_FFFF, 32'h1234_0000, 4'b0001, 32'h1234_FFFF, 1'b0, 1'b0);
        run_op("add_cy",  32'hFFFF_FFFF, 32'h0000_0002, 4'b0010, 32'h0000_0001, 1'b1, 1'b0);
        run_op("illegal", 32'h1234_5678, 32'h0F0F_0F0F, 4'b0101, 32'd0, 1'b0, 1'b0);

        // Slice drive check on the first bit of a SUB, then abort with reset at k=10.
        run_op("pre_rst", 32'd9, 32'd4, 4'b0010, 32'd13, 1'b0, 1'b0);
        src1_i  = 32'h0000_0100;
        src2_i  = 32'h0000_0201;
        ctrl_i  = 4'b0110;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("sub_k0_op", {30'd0, slice_op_o}, 32'd2);
        chk("sub_k0_binv", {31'd0, slice_binvert_o}, 32'd1);
        chk("sub_k0_cin", {31'd0, slice_cin_o}, 32'd1);
        chk("sub_k0_src2", {31'd0, slice_src2_o}, 32'd1);
        repeat (10) @(posedge clk_i);
        #1;
        chk("run_hold_result", result_o, 32'd13);
        rst_i = 1'b1;
        #1;
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_result", result_o, 32'd0);
        chk("abort_zero", {31'd0, zero_o}, 32'd1);
        chk("abort_flags", {30'd0, cout_o, overflow_o}, 32'd0);
        chk("abort_slice", {24'd0, slice_src1_o, slice_src2_o, slice_less_o, slice_ainvert_o,
                            slice_binvert_o, slice_cin_o, slice_op_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);
        run_op("add_after_rst", 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 1'b0);

        // Start pulses with new operands during RUN and DONE are ignored.
        src1_i  = 32'd10;
        src2_i  = 32'd20;
        ctrl_i  = 4'b0010;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        src1_i  = 32'hFFFF_0000;
        src2_i  = 32'h0000_FFFF;
        ctrl_i  = 4'b0110;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("ign_ready_run", {31'd0, ready_o}, 32'd0);
        n = 0;
        while (!done_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("ign_latency", n, 32'd27);
        chk("ign_result", result_o, 32'd30);
        start_i = 1'b1;
        chk("ign_ready_done", {31'd0, ready_o}, 32'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("ign_ready_idle", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        chk("ign_no_queue", {31'd0, ready_o}, 32'd1);
        chk("ign_result_hold", result_o, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
